// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: gathers A, B, opcode bytes from the UART receiver,
// drives the ALU, and sends the result back through one transmitter frame.
module uart_alu_sequencer #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  localparam int NB_CNT = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_B,
    S_WAIT_OP,
    S_EXEC,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NB_CNT-1:0]  r_cnt;
  logic [NB_CNT-1:0]  w_cnt_nxt;
  logic [NB_DATA-1:0] r_alu_a, w_alu_a_nxt;
  logic [NB_DATA-1:0] r_alu_b, w_alu_b_nxt;
  logic [NB_OP-1:0]   r_alu_op, w_alu_op_nxt;
  logic [NB_DATA-1:0] r_tx_data, w_tx_data_nxt;
  logic               r_tx_start, w_tx_start_nxt;
  logic               r_busy;
  logic               r_timeout, w_timeout_nxt;
  logic               r_overrun, w_overrun_nxt;
  logic               w_expired;

  // A byte landing on the last allowed cycle wins over the timeout.
  assign w_expired = (r_cnt == CNT_LAST) && !i_rx_done_tick;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_rx_done_tick) w_state_nxt = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (i_rx_done_tick) w_state_nxt = S_WAIT_OP;
        else if (w_expired) w_state_nxt = S_IDLE;
      end
      S_WAIT_OP: begin
        if (i_rx_done_tick) w_state_nxt = S_EXEC;
        else if (w_expired) w_state_nxt = S_IDLE;
      end
      S_EXEC:    w_state_nxt = S_SEND;
      S_SEND:    w_state_nxt = S_WAIT_TX;
      S_WAIT_TX: begin
        if (i_tx_done_tick) w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt      = '0;
    w_alu_a_nxt    = r_alu_a;
    w_alu_b_nxt    = r_alu_b;
    w_alu_op_nxt   = r_alu_op;
    w_tx_data_nxt  = r_tx_data;
    w_tx_start_nxt = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_overrun_nxt  = r_overrun;
    unique case (r_state)
      S_IDLE: begin
        if (i_rx_done_tick) begin
          w_alu_a_nxt   = i_rx_data;
          w_overrun_nxt = 1'b0;
        end
      end
      S_WAIT_B: begin
        if (i_rx_done_tick) begin
          w_alu_b_nxt = i_rx_data;
        end else begin
          w_cnt_nxt     = w_expired ? '0 : r_cnt + NB_CNT'(1);
          w_timeout_nxt = w_expired;
        end
      end
      S_WAIT_OP: begin
        if (i_rx_done_tick) begin
          w_alu_op_nxt = i_rx_data[NB_OP-1:0];
        end else begin
          w_cnt_nxt     = w_expired ? '0 : r_cnt + NB_CNT'(1);
          w_timeout_nxt = w_expired;
        end
      end
      S_SEND: begin
        w_tx_data_nxt  = i_alu_result;
        w_tx_start_nxt = 1'b1;
        if (i_rx_done_tick) w_overrun_nxt = 1'b1;
      end
      default: begin
        if (i_rx_done_tick) w_overrun_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_alu_a    <= w_alu_a_nxt;
      r_alu_b    <= w_alu_b_nxt;
      r_alu_op   <= w_alu_op_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_timeout  <= w_timeout_nxt;
      r_overrun  <= w_overrun_nxt;
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = r_busy;
  assign o_timeout  = r_timeout;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: byte-level stimulus, behavioural ALU and
// transmitter, a per-cycle command model plus literal spot checks.
module tb_uart_alu_sequencer;

  localparam int TO    = 1000;
  localparam int TXLEN = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] alu_res;
  logic       tx_done = 1'b0;
  logic       inj_done = 1'b0;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, busy, tmo, ovr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int n_starts = 0, start_cyc = 0;
  int n_tmo = 0, tmo_cyc = 0;
  int last_rx_edge = 0;
  int tx_cnt = 0;

  logic [7:0] m_a = 0, m_b = 0, m_txd = 0;
  logic [5:0] m_op = 0;
  logic       m_start = 0, m_tmo = 0, m_ovr = 0, m_tx = 0;
  int         m_bytes = 0, m_lat = 0, m_age = 0;

  always #10 clk = ~clk;

  uart_alu_sequencer #(
    .NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_rx_done_tick(rx_tick),
    .i_rx_data(rx_data),
    .i_alu_result(alu_res),
    .i_tx_done_tick(tx_done),
    .o_alu_a(alu_a),
    .o_alu_b(alu_b),
    .o_alu_op(alu_op),
    .o_tx_start(tx_start),
    .o_tx_data(tx_data),
    .o_busy(busy),
    .o_timeout(tmo),
    .o_overrun(ovr)
  );

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      default:   return 8'h00;
    endcase
  endfunction

  assign alu_res = alu(alu_a, alu_b, alu_op);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Command-level reference: bytes collected, cycles since opcode, tx pending.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_op = 0; m_txd = 0;
      m_start = 0; m_tmo = 0; m_ovr = 0; m_tx = 0;
      m_bytes = 0; m_lat = 0; m_age = 0;
    end else begin
      m_start = 0;
      m_tmo = 0;
      if (m_tx) begin
        if (rx_tick) m_ovr = 1;
        if (tx_done) m_tx = 0;
      end else if (m_bytes == 3) begin
        if (rx_tick) m_ovr = 1;
        m_lat++;
        if (m_lat == 2) begin
          m_txd = alu(m_a, m_b, m_op);
          m_start = 1;
          m_tx = 1;
          m_bytes = 0;
        end
      end else if (rx_tick) begin
        case (m_bytes)
          0: begin m_a = rx_data; m_ovr = 0; end
          1: m_b = rx_data;
          default: begin m_op = rx_data[5:0]; m_lat = 0; end
        endcase
        m_bytes++;
        m_age = 0;
      end else if (m_bytes != 0) begin
        if (m_age == TO - 1) begin
          m_bytes = 0;
          m_tmo = 1;
        end else begin
          m_age++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (tx_start) begin n_starts++; start_cyc = cyc; end
    if (tmo) begin n_tmo++; tmo_cyc = cyc; end
    if (rst_n) begin
      n_tests++;
      if ({alu_a, alu_b, alu_op, tx_start, tx_data, busy, tmo, ovr} !==
          {m_a, m_b, m_op, m_start, m_txd, (m_tx || m_bytes != 0), m_tmo, m_ovr}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL model cyc %0d: dut a=%h b=%h op=%h st=%b txd=%h busy=%b tmo=%b ovr=%b, want a=%h b=%h op=%h st=%b txd=%h busy=%b tmo=%b ovr=%b",
                   cyc, alu_a, alu_b, alu_op, tx_start, tx_data, busy, tmo, ovr,
                   m_a, m_b, m_op, m_start, m_txd, (m_tx || m_bytes != 0), m_tmo, m_ovr);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    tx_done = inj_done;
    if (!rst_n) tx_cnt = 0;
    else if (tx_start) tx_cnt = TXLEN;
    else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_done = 1'b1;
    end
  end

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_tick = 1'b1;
    rx_data = b;
    last_rx_edge = cyc + 1;
    @(negedge clk);
    rx_tick = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a);
    gap(4);
    send_byte(b);
    gap(4);
    send_byte(op);
  endtask

  task automatic inject();
    @(negedge clk);
    #1 inj_done = 1'b1;
    @(negedge clk);
    #1 inj_done = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int k = 0;
    @(negedge clk);
    while (busy && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check({name, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_start(input string name, input int maxc);
    int k = 0;
    while (!tx_start && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check({name, " start seen"}, {31'd0, tx_start}, 32'd1);
  endtask

  int s0, t0, k;

  initial begin
    #25;
    check("reset outputs", {alu_a, alu_b, alu_op, tx_start, tx_data, busy, tmo, ovr}, 32'd0);
    gap(2);
    rst_n = 1'b1;

    inject();
    gap(2);
    check("stray done idle", {31'd0, busy}, 32'd0);

    s0 = n_starts;
    cmd(8'h05, 8'h03, 8'h20);
    wait_idle("add", 200);
    check("add a", alu_a, 32'h05);
    check("add b", alu_b, 32'h03);
    check("add op", alu_op, 32'h20);
    check("add result", tx_data, 32'h08);
    check("add starts", n_starts - s0, 32'd1);
    check("add latency", start_cyc - last_rx_edge, 32'd2);

    send_byte(8'h03);
    inject();
    send_byte(8'h05);
    gap(3);
    send_byte(8'h22);
    wait_idle("sub", 200);
    check("sub result", tx_data, 32'hFE);
    cmd(8'h03, 8'h05, 8'hE2);
    wait_idle("sub hi", 200);
    check("sub hi op", alu_op, 32'h22);
    check("sub hi result", tx_data, 32'hFE);

    t0 = n_tmo;
    send_byte(8'h11);
    wait_idle("timeout", TO + 100);
    check("timeout count", n_tmo - t0, 32'd1);
    check("timeout time", tmo_cyc - last_rx_edge, TO);
    send_byte(8'h01);
    gap(TO - 2);
    send_byte(8'h02);
    gap(3);
    send_byte(8'h20);
    wait_idle("edge byte", 200);
    check("edge no timeout", n_tmo - t0, 32'd1);
    check("edge result", tx_data, 32'h03);

    cmd(8'h07, 8'h01, 8'h20);
    wait_start("ovr", 50);
    gap(3);
    send_byte(8'hAA);
    check("ovr set", {31'd0, ovr}, 32'd1);
    check("ovr txd kept", tx_data, 32'h08);
    wait_idle("ovr", 200);
    check("ovr sticky", {31'd0, ovr}, 32'd1);
    send_byte(8'h01);
    check("ovr cleared", {31'd0, ovr}, 32'd0);
    gap(2);
    send_byte(8'h01);
    gap(2);
    send_byte(8'h20);
    wait_idle("ovr next", 200);
    check("ovr next result", tx_data, 32'h02);

    send_byte(8'h05);
    gap(2);
    send_byte(8'h03);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check("async reset", {alu_a, alu_b, alu_op, tx_start, tx_data, busy, tmo, ovr}, 32'd0);
    gap(3);
    @(negedge clk);
    rst_n = 1'b1;
    cmd(8'h05, 8'h03, 8'h20);
    wait_idle("post reset", 200);
    check("post reset result", tx_data, 32'h08);

    cmd(8'h09, 8'h04, 8'h20);
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!tx_done && k < 300);
    check("b2b done seen", {31'd0, tx_done}, 32'd1);
    send_byte(8'h10);
    check("b2b first result", tx_data, 32'h0D);
    check("b2b a", alu_a, 32'h10);
    check("b2b busy", {31'd0, busy}, 32'd1);
    gap(2);
    send_byte(8'h02);
    gap(2);
    send_byte(8'h22);
    wait_idle("b2b", 200);
    check("b2b result", tx_data, 32'h0E);

    gap(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
